req_ack_responder: RTL and testbench
====================================

REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

Interface
REQ-001 Parameter DATA_W, default 8, width of request/response payload.
REQ-002 Parameter HS_CNT_W, default 16, width of handshake counter.
REQ-003 Parameter ERR_CNT_W, default 8, width of error counter.
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  1  request from initiator; legal form is a one-cycle pulse.
REQ-007 req_data  input  DATA_W  payload, valid in the cycle req rises.
REQ-008 ack  output  1  acknowledge; one-cycle pulse.
REQ-009 ack_data  output  DATA_W  response payload, valid while ack=1, else 0.
REQ-010 busy  output  1  high while a handshake is outstanding (WAIT or ACK state).
REQ-011 err  output  1  sticky protocol-error flag.
REQ-012 err_clr  input  1  clears err and err_count.
REQ-013 hs_count  output  HS_CNT_W  completed handshakes, saturating.
REQ-014 err_count  output  ERR_CNT_W  protocol violations, saturating.

Function
REQ-015 Rise of req is detected as req=1 with previous-cycle req=0; previous-req register resets to 0, so req=1 in the first cycle after reset counts as a rise.
REQ-016 FSM states IDLE, WAIT, ACK; reset state IDLE.
REQ-017 IDLE: on rise, capture req_data, go to WAIT; otherwise stay.
REQ-018 WAIT: if req=0, go to ACK; if req=1 (req held >1 cycle), log a violation, discard the captured data, return to IDLE, and assert no ack.
REQ-019 ACK: assert ack=1 and ack_data=captured data, increment hs_count, return to IDLE.
REQ-020 Latency: a rise at cycle t gives ack=1 at exactly t+2, ack=0 at t+1 and at t+3.
REQ-021 ack is driven combinationally from state==ACK with no other logic; ack_data is 0 outside ACK.
REQ-022 Rise in ACK (ack still high) is a violation: log it, ignore the request, and still complete the current ack.
REQ-023 Rise in IDLE at t+3 (back-to-back) is accepted, giving a sustained throughput of one handshake per 3 cycles.
REQ-024 Each violation sets err=1 and increments err_count by 1, saturating at all-ones.
REQ-025 hs_count saturates at all-ones and never wraps.
REQ-026 err_clr=1 clears err and err_count next cycle; if a violation occurs in the same cycle, the violation wins: err=1, err_count=1.
REQ-027 err_clr does not affect the FSM, hs_count or an in-flight handshake.

Reset
REQ-028 While rst=1, the following hold next cycle: state=IDLE, ack=0, ack_data=0, busy=0, err=0, hs_count=0, err_count=0, captured data=0, previous-req register=0.
REQ-029 Reset mid-handshake (WAIT or ACK) aborts it; no ack is issued after reset deasserts for that request.
REQ-030 rst has priority over all other inputs.

Structure
REQ-031 Package req_ack_pkg holds the FSM state enum (IDLE, WAIT, ACK) and the default width constants.
REQ-032 Sub-module req_ack_edge_det (clk, rst, in, rise, fall) provides the previous-value register and edge pulses.
REQ-033 All outputs are registered or decoded directly from registered state; no input-to-output combinational path.

Verification
REQ-034 Single pulse: req=1 at cycle 5 (req_data=0xA5), 0 after -> ack=1, ack_data=0xA5 at cycle 7 only; hs_count=1; err=0.
REQ-035 Back-to-back: req pulses at cycles 5, 8, 11 -> acks at 7, 10, 13; hs_count=3; err_count=0.
REQ-036 Stuck req: req high cycles 5-6 -> no ack; err=1, err_count=1 at cycle 7; FSM in IDLE.
REQ-037 Overlap: req pulses at 5 and 7 -> single ack at 7 carrying the first data; err_count=1; no ack at 9.
REQ-038 Reset mid-op: req pulse at 5, rst=1 at cycle 6 -> no ack at 7; all outputs 0.
REQ-039 Saturation and clear: ERR_CNT_W=2, drive 5 violations -> err_count=3; err_clr concurrent with a violation -> err=1, err_count=1.

Source files
------------

// File: rtl/req_ack_pkg.sv
// Shared definitions for the request/acknowledge responder:
// the handshake FSM state encoding and default widths.
package req_ack_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_HS_CNT_W  = 16;
    localparam int DEF_ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/req_ack_edge_det.sv
// Previous-value register with rise/fall pulses.
// The register clears on reset, so a high input right after reset reads as a rise.
module req_ack_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise,
    output logic fall
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in;
        end
    end

    assign rise = in & ~prev_q;
    assign fall = ~in & prev_q;

endmodule

// File: rtl/req_ack_responder.sv
// Responds to a one-cycle req pulse with a one-cycle ack two cycles later,
// echoing the captured payload; counts handshakes and protocol violations.
//
// Handshake: req is a single-cycle pulse with req_data valid in that cycle;
// ack is a single-cycle pulse exactly two cycles later with ack_data valid only
// while ack=1. A req held high into the following cycle, or a new req rise
// during the ack cycle, is a protocol violation and is logged, not acked.
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int HS_CNT_W  = DEF_HS_CNT_W,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [DATA_W-1:0]    req_data,
    output logic                 ack,
    output logic [DATA_W-1:0]    ack_data,
    output logic                 busy,
    output logic                 err,
    input  logic                 err_clr,
    output logic [HS_CNT_W-1:0]  hs_count,
    output logic [ERR_CNT_W-1:0] err_count,
    output state_t               dbg_state
);

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [HS_CNT_W-1:0]    hs_q, hs_d;
    logic [ERR_CNT_W-1:0]   errc_q, errc_d;
    logic                   err_q, err_d;
    logic                   viol;
    logic                   req_rise;
    logic                   req_fall;

    req_ack_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (req),
        .rise (req_rise),
        .fall (req_fall)
    );

    // WAIT is only entered on a rise, so req=0 there is exactly a fall.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        hs_d    = hs_q;
        viol    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_rise) begin
                    data_d  = req_data;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (req_fall) begin
                    state_d = ACK;
                end else begin
                    viol    = 1'b1;
                    data_d  = '0;
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = IDLE;
                if (hs_q != '1) begin
                    hs_d = hs_q + 1'b1;
                end
                if (req_rise) begin
                    viol = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A violation in the same cycle as err_clr wins and restarts the count at one.
    always_comb begin
        err_d  = err_q;
        errc_d = errc_q;
        if (viol) begin
            err_d = 1'b1;
            if (err_clr) begin
                errc_d = ERR_CNT_W'(1);
            end else if (errc_q != '1) begin
                errc_d = errc_q + 1'b1;
            end
        end else if (err_clr) begin
            err_d  = 1'b0;
            errc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            hs_q    <= '0;
            errc_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            hs_q    <= hs_d;
            errc_q  <= errc_d;
            err_q   <= err_d;
        end
    end

    assign ack       = (state_q == ACK);
    assign ack_data  = ack ? data_q : '0;
    assign busy      = (state_q == WAIT) || (state_q == ACK);
    assign err       = err_q;
    assign hs_count  = hs_q;
    assign err_count = errc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: directed scenarios plus random req/rst/err_clr
// traffic, checked against a timestamp-based handshake model via a scoreboard.
module tb_req_ack_responder;
    import req_ack_pkg::*;

    localparam int DW      = 8;
    localparam int HW      = 4;
    localparam int EW      = 2;
    localparam int HS_MAX  = (1 << HW) - 1;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [DW-1:0] req_data;
    logic          err_clr;
    logic          ack;
    logic [DW-1:0] ack_data;
    logic          busy;
    logic          err;
    logic [HW-1:0] hs_count;
    logic [EW-1:0] err_count;
    state_t        dbg_state;

    req_ack_responder #(
        .DATA_W    (DW),
        .HS_CNT_W  (HW),
        .ERR_CNT_W (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .ack_data  (ack_data),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr),
        .hs_count  (hs_count),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle index ----------------
    always #5 clk = ~clk;

    int cyc_q = 0;
    always @(posedge clk) cyc_q <= cyc_q + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int            cyc;
        logic          busy;
        logic          err;
        logic [EW-1:0] errc;
        logic [HW-1:0] hs;
    } st_t;

    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    st_t           st_q[$];
    int            n_vec = 0;
    int            n_mis = 0;
    logic          mon_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_mis++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_q, act, exp_v);
        end
    endfunction

    // ---------------- reference model ----------------
    // A rise accepted at t owns cycle t+1 (must see req low) and then acks at t+2.
    int            m_wait = -1;
    int            m_ack  = -1;
    logic          m_prev = 1'b0;
    logic [DW-1:0] m_data = '0;
    int            m_hs   = 0;
    int            m_errc = 0;
    logic          m_err  = 1'b0;

    function automatic void model_apply(input int t, input logic r, input logic q,
                                        input logic [DW-1:0] d, input logic c);
        logic rise;
        logic viol;
        st_t  s;
        if (r) begin
            m_wait = -1;
            m_ack  = -1;
            m_prev = 1'b0;
            m_data = '0;
            m_hs   = 0;
            m_errc = 0;
            m_err  = 1'b0;
        end else begin
            rise = q && !m_prev;
            viol = 1'b0;
            if (t == m_wait) begin
                m_wait = -1;
                if (q) begin
                    viol = 1'b1;
                end else begin
                    m_ack = t + 1;
                    exp_q.push_back(m_data);
                    exp_cyc_q.push_back(t + 1);
                end
            end else if (t == m_ack) begin
                m_ack = -1;
                if (m_hs < HS_MAX) m_hs++;
                if (rise) viol = 1'b1;
            end else if (rise) begin
                m_data = d;
                m_wait = t + 1;
            end
            if (viol) begin
                m_err  = 1'b1;
                m_errc = c ? 1 : ((m_errc < ERR_MAX) ? m_errc + 1 : m_errc);
            end else if (c) begin
                m_err  = 1'b0;
                m_errc = 0;
            end
            m_prev = q;
        end
        s.cyc  = t + 1;
        s.busy = (m_wait == t + 1) || (m_ack == t + 1);
        s.err  = m_err;
        s.errc = EW'(m_errc);
        s.hs   = HW'(m_hs);
        st_q.push_back(s);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic q, input logic [DW-1:0] d, input logic c);
        int t;
        @(negedge clk);
        t        = cyc_q;
        rst      = r;
        req      = q;
        req_data = d;
        err_clr  = c;
        model_apply(t, r, q, d, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW'($urandom), 1'b0);
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        step(1'b0, 1'b1, d, 1'b0);
        step(1'b0, 1'b0, DW'($urandom), 1'b0);
        step(1'b0, 1'b0, DW'($urandom), 1'b0);
    endtask

    task automatic stuck(input logic c);
        step(1'b0, 1'b1, DW'($urandom), 1'b0);
        step(1'b0, 1'b1, DW'($urandom), c);
        step(1'b0, 1'b0, DW'($urandom), 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        int  now;
        st_t s;
        wait (mon_en);
        forever begin
            @(negedge clk);
            now = cyc_q;
            while (st_q.size() > 0 && st_q[0].cyc < now) void'(st_q.pop_front());
            if (st_q.size() > 0 && st_q[0].cyc == now) begin
                s = st_q.pop_front();
                check("busy", busy, s.busy);
                check("err", err, s.err);
                check("err_count", err_count, s.errc);
                check("hs_count", hs_count, s.hs);
            end
            if (ack === 1'b1) begin
                if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == now) begin
                    check("ack_data", ack_data, exp_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end else begin
                    check("unexpected_ack", ack, 1'b0);
                end
            end else begin
                if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= now) begin
                    check("missing_ack", ack, 1'b1);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
                check("idle_ack_data", ack_data, '0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        req      = 1'b0;
        req_data = '0;
        err_clr  = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
        mon_en = 1'b1;
        idle(2);

        // single pulse
        pulse(8'hA5);
        idle(3);

        // back-to-back at a 3-cycle pitch
        for (int i = 0; i < 3; i++) pulse(DW'($urandom));
        idle(3);

        // req held for two cycles
        stuck(1'b0);
        check("stuck_state", dbg_state, IDLE);
        idle(2);

        // second rise during the ack cycle
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hC3, 1'b0);
        idle(4);

        // reset in the WAIT cycle
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(4);

        // reset in the ACK cycle
        step(1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(3);

        // handshake counter saturation
        for (int i = 0; i < HS_MAX + 3; i++) pulse(DW'($urandom));
        idle(2);

        // error counter saturation and clear/violation collision
        step(1'b1, 1'b0, '0, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) stuck(1'b0);
        check("err_sat", err_count, 2'd3);
        stuck(1'b1);
        check("clr_collide_cnt", err_count, 2'd1);
        check("clr_collide_err", err, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(2);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 40,
                 DW'($urandom),
                 $urandom_range(0, 99) < 4);
        end
        idle(6);
        check("queue_drain", exp_cyc_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
